// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared CPU definitions: fetch exception bits, fetch FSM state
//               encoding and stall-vector bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam logic [31:0] EXC_ADEL_IF = 32'h0000_0010;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_CANCEL = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_REQ    = ST_REQ,
        S_WAIT   = ST_WAIT,
        S_DONE   = ST_DONE,
        S_CANCEL = ST_CANCEL
    } fetch_state_e;

    localparam int STALL_INST = 0;
    localparam int STALL_ID   = 1;
    localparam int STALL_EXE  = 2;
    localparam int STALL_DATA = 3;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/postif_fetch.sv
`default_nettype none
// ============================================================================
// Module      : postif_fetch
// Description : Post-IF fetch stage. One SRAM-like instruction-bus read per
//               PC, result held for the postif_id register; flush-safe.
// Revision    : 1.0 - initial release
// ============================================================================
module postif_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_pc_valid_i,
    input  logic        exception_i,
    input  logic [3:0]  stall_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] postif_pc_o,
    output logic [31:0] postif_inst_o,
    output logic [31:0] postif_exception_type_o,
    output logic        postif_inst_ren_o,
    output logic        postif_inst_ok_o,
    output logic        postif_inst_valid_o,
    output logic        fetch_stall_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic [31:0] r_exc;
    logic        r_inst_ok;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_exc_nxt;
    logic        w_inst_ok_nxt;

    logic w_downstream_stall;
    logic w_launch;
    logic w_clear;
    logic w_unused_inst_stall;

    // The inst-stall bit is this stage's own request fed back; nothing to act on.
    assign w_unused_inst_stall = stall_i[STALL_INST];
    assign w_downstream_stall  = stall_i[STALL_ID] | stall_i[STALL_EXE] | stall_i[STALL_DATA];

    // ------------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_addr_nxt    = r_addr;
        w_inst_nxt    = r_inst;
        w_exc_nxt     = r_exc;
        w_inst_ok_nxt = 1'b0;
        w_launch      = 1'b0;
        w_clear       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (exception_i) begin
                    w_clear = 1'b1;
                end else if (if_pc_valid_i && !w_downstream_stall) begin
                    w_launch = 1'b1;
                end
            end

            S_REQ: begin
                if (exception_i) begin
                    w_clear     = 1'b1;
                    // An accepted address means a response is still coming back.
                    w_state_nxt = inst_addr_ok_i ? S_CANCEL : S_IDLE;
                end else if (inst_addr_ok_i) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (exception_i) begin
                    w_clear     = 1'b1;
                    w_state_nxt = inst_data_ok_i ? S_IDLE : S_CANCEL;
                end else if (inst_data_ok_i) begin
                    w_inst_nxt    = inst_rdata_i;
                    w_exc_nxt     = 32'h0;
                    w_inst_ok_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end
            end

            S_DONE: begin
                if (exception_i) begin
                    w_clear = 1'b1;
                end else if (!w_downstream_stall) begin
                    if (if_pc_valid_i) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_CANCEL: begin
                // Outputs stay cleared; only the orphaned response is awaited.
                w_clear = exception_i;
                if (inst_data_ok_i) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_clear     = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_launch) begin
            w_pc_nxt   = if_pc_i;
            w_inst_nxt = 32'h0;
            if (pc_aligned(if_pc_i)) begin
                w_addr_nxt  = if_pc_i;
                w_exc_nxt   = 32'h0;
                w_state_nxt = S_REQ;
            end else begin
                w_addr_nxt  = 32'h0;
                w_exc_nxt   = EXC_ADEL_IF;
                w_state_nxt = S_DONE;
            end
        end

        if (w_clear) begin
            w_pc_nxt      = RESET_PC;
            w_addr_nxt    = 32'h0;
            w_inst_nxt    = 32'h0;
            w_exc_nxt     = 32'h0;
            w_inst_ok_nxt = 1'b0;
            if (r_state == S_IDLE || r_state == S_DONE) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State and holding registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= 32'h0;
            r_inst    <= 32'h0;
            r_exc     <= 32'h0;
            r_inst_ok <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_addr    <= w_addr_nxt;
            r_inst    <= w_inst_nxt;
            r_exc     <= w_exc_nxt;
            r_inst_ok <= w_inst_ok_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: registers or pure state decode only
    // ------------------------------------------------------------------------
    assign inst_req_o              = (r_state == S_REQ);
    assign inst_addr_o             = r_addr;
    assign postif_pc_o             = r_pc;
    assign postif_inst_o           = r_inst;
    assign postif_exception_type_o = r_exc;
    assign postif_inst_ren_o       = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_CANCEL);
    assign postif_inst_ok_o        = r_inst_ok;
    assign postif_inst_valid_o     = (r_state == S_DONE);
    assign fetch_stall_o           = postif_inst_ren_o;

endmodule
`default_nettype wire

// File: tb/tb_postif_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_postif_fetch
// Description : Directed self-checking bench for postif_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_postif_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h1FC0_0000;

    logic        clk;
    logic        reset_i;
    logic [31:0] if_pc_i;
    logic        if_pc_valid_i;
    logic        exception_i;
    logic [3:0]  stall_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic [31:0] postif_pc_o;
    logic [31:0] postif_inst_o;
    logic [31:0] postif_exception_type_o;
    logic        postif_inst_ren_o;
    logic        postif_inst_ok_o;
    logic        postif_inst_valid_o;
    logic        fetch_stall_o;

    int checks   = 0;
    int failures = 0;

    postif_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clock_i                 (clk),
        .reset_i                 (reset_i),
        .if_pc_i                 (if_pc_i),
        .if_pc_valid_i           (if_pc_valid_i),
        .exception_i             (exception_i),
        .stall_i                 (stall_i),
        .inst_req_o              (inst_req_o),
        .inst_addr_o             (inst_addr_o),
        .inst_addr_ok_i          (inst_addr_ok_i),
        .inst_data_ok_i          (inst_data_ok_i),
        .inst_rdata_i            (inst_rdata_i),
        .postif_pc_o             (postif_pc_o),
        .postif_inst_o           (postif_inst_o),
        .postif_exception_type_o (postif_exception_type_o),
        .postif_inst_ren_o       (postif_inst_ren_o),
        .postif_inst_ok_o        (postif_inst_ok_o),
        .postif_inst_valid_o     (postif_inst_valid_o),
        .fetch_stall_o           (fetch_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags: {req, ren, stall, valid, ok}
    task automatic chk_flags(input string tag, input logic [4:0] exp);
        chk(tag, {27'h0, inst_req_o, postif_inst_ren_o, fetch_stall_o,
                  postif_inst_valid_o, postif_inst_ok_o}, {27'h0, exp});
    endtask

    initial begin
        reset_i        = 1'b0;
        if_pc_i        = 32'h0;
        if_pc_valid_i  = 1'b0;
        exception_i    = 1'b0;
        stall_i        = 4'b0000;
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'h0;

        // Reset
        tick(); tick();
        chk_flags("rst_flags", 5'b00000);
        chk("rst_addr", inst_addr_o, 32'h0);
        chk("rst_pc", postif_pc_o, C_RESET_PC);
        chk("rst_inst", postif_inst_o, 32'h0);
        chk("rst_exc", postif_exception_type_o, 32'h0);
        reset_i = 1'b1;

        // Zero-wait fetch of 0xBFC0_0000
        if_pc_i = 32'hBFC0_0000; if_pc_valid_i = 1'b1;
        tick();
        chk_flags("zw_req_flags", 5'b11100);
        chk("zw_req_addr", inst_addr_o, 32'hBFC0_0000);
        if_pc_valid_i = 1'b0; inst_addr_ok_i = 1'b1;
        tick();
        chk_flags("zw_wait_flags", 5'b01100);
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h2408_0001;
        tick();
        inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;
        chk_flags("zw_done_flags", 5'b00011);
        chk("zw_done_pc", postif_pc_o, 32'hBFC0_0000);
        chk("zw_done_inst", postif_inst_o, 32'h2408_0001);
        chk("zw_done_exc", postif_exception_type_o, 32'h0);
        tick();
        chk_flags("zw_idle_flags", 5'b00000);

        // Misaligned PC: no bus request, straight to DONE with ADEL
        if_pc_i = 32'hBFC0_0002; if_pc_valid_i = 1'b1;
        tick();
        if_pc_valid_i = 1'b0;
        chk_flags("mis_flags", 5'b00010);
        chk("mis_pc", postif_pc_o, 32'hBFC0_0002);
        chk("mis_inst", postif_inst_o, 32'h0);
        chk("mis_exc", postif_exception_type_o, 32'h0000_0010);
        tick();
        chk_flags("mis_idle_flags", 5'b00000);

        // Fetch 0xBFC0_0004 then hold in DONE under exe stall
        if_pc_i = 32'hBFC0_0004; if_pc_valid_i = 1'b1;
        tick();
        if_pc_valid_i = 1'b0; inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hAAAA_5555;
        tick();
        inst_data_ok_i = 1'b0;
        stall_i = 4'b0100; if_pc_i = 32'hBFC0_0008; if_pc_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_flags("stl_flags", 5'b00010);
            chk("stl_pc", postif_pc_o, 32'hBFC0_0004);
            chk("stl_inst", postif_inst_o, 32'hAAAA_5555);
        end
        stall_i = 4'b0000;
        tick();
        if_pc_valid_i = 1'b0;
        chk_flags("rel_req_flags", 5'b11100);
        chk("rel_req_addr", inst_addr_o, 32'hBFC0_0008);

        // Flush in WAIT, data_ok two cycles later
        inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0; exception_i = 1'b1;
        tick();
        exception_i = 1'b0;
        if_pc_i = 32'hBFC0_000C; if_pc_valid_i = 1'b1;
        chk_flags("fw_cancel_flags", 5'b01100);
        chk("fw_cancel_pc", postif_pc_o, C_RESET_PC);
        chk("fw_cancel_addr", inst_addr_o, 32'h0);
        tick();
        chk_flags("fw_cancel2_flags", 5'b01100);
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
        tick();
        inst_data_ok_i = 1'b0;
        chk_flags("fw_idle_flags", 5'b00000);
        chk("fw_idle_inst", postif_inst_o, 32'h0);
        tick();
        if_pc_valid_i = 1'b0;
        chk_flags("fw_newreq_flags", 5'b11100);
        chk("fw_newreq_addr", inst_addr_o, 32'hBFC0_000C);

        // Flush coincident with addr_ok in REQ
        inst_addr_ok_i = 1'b1; exception_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0; exception_i = 1'b0;
        chk_flags("fa_cancel_flags", 5'b01100);
        tick();
        chk_flags("fa_cancel2_flags", 5'b01100);
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h1234_5678;
        tick();
        inst_data_ok_i = 1'b0;
        chk_flags("fa_idle_flags", 5'b00000);
        chk("fa_idle_inst", postif_inst_o, 32'h0);

        // Flush in REQ without addr_ok: straight back to IDLE
        if_pc_i = 32'hBFC0_0010; if_pc_valid_i = 1'b1;
        tick();
        if_pc_valid_i = 1'b0; exception_i = 1'b1;
        tick();
        exception_i = 1'b0;
        chk_flags("fr_idle_flags", 5'b00000);
        chk("fr_idle_pc", postif_pc_o, C_RESET_PC);

        // Flush in WAIT with data_ok same cycle: data dropped, IDLE
        if_pc_i = 32'hBFC0_0014; if_pc_valid_i = 1'b1;
        tick();
        if_pc_valid_i = 1'b0; inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h5555_AAAA;
        exception_i = 1'b1;
        tick();
        inst_data_ok_i = 1'b0; exception_i = 1'b0;
        chk_flags("fd_idle_flags", 5'b00000);
        chk("fd_idle_inst", postif_inst_o, 32'h0);

        // Back-to-back: DONE consumes and launches the next PC directly
        if_pc_i = 32'hBFC0_0020; if_pc_valid_i = 1'b1;
        tick();
        if_pc_valid_i = 1'b0; inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h0000_0021;
        tick();
        inst_data_ok_i = 1'b0;
        chk("b2b_done1_inst", postif_inst_o, 32'h0000_0021);
        if_pc_i = 32'hBFC0_0024; if_pc_valid_i = 1'b1;
        tick();
        if_pc_valid_i = 1'b0;
        chk_flags("b2b_req_flags", 5'b11100);
        chk("b2b_req_addr", inst_addr_o, 32'hBFC0_0024);

        // Reset mid-transaction goes straight to IDLE
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        chk_flags("mrst_flags", 5'b00000);
        chk("mrst_pc", postif_pc_o, C_RESET_PC);
        chk("mrst_addr", inst_addr_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/postif_fetch.md
# postif_fetch

Post-IF fetch stage. It accepts the fetch PC from the PC register, runs one SRAM-like instruction-bus transaction per PC, and presents PC, instruction and fetch exception type to the `postif_id` pipeline register. It raises the instruction-stall request while a transaction is outstanding. On a pipeline flush it discards any response already in flight.

## Interface
Parameters
- `RESET_PC`, 32'h0000_0000: value of `postif_pc_o` after reset and flush.

Ports
- `clock_i`  in  1  single clock; all state updates on its rising edge.
- `reset_i`  in  1  reset, synchronous, active-low (0 = reset).
- `if_pc_i`  in  32  next fetch PC.
- `if_pc_valid_i`  in  1  `if_pc_i` is a real fetch.
- `exception_i`  in  1  pipeline flush.
- `stall_i`  in  4  {data, exe, id, inst} stall bits; `downstream_stall` = |stall_i[3:1].
- `inst_req_o`  out  1  SRAM-like request.
- `inst_addr_o`  out  32  request address.
- `inst_addr_ok_i`  in  1  address handshake accepted.
- `inst_data_ok_i`  in  1  read data returned.
- `inst_rdata_i`  in  32  read data.
- `postif_pc_o`  out  32  PC of the held instruction.
- `postif_inst_o`  out  32  held instruction word.
- `postif_exception_type_o`  out  32  fetch exception bits.
- `postif_inst_ren_o`  out  1  a transaction is outstanding (REQ/WAIT/CANCEL).
- `postif_inst_ok_o`  out  1  `inst_data_ok_i` accepted this cycle (not in CANCEL).
- `postif_inst_valid_o`  out  1  the outputs hold a valid fetched instruction (DONE).
- `fetch_stall_o`  out  1  inst-stall request to the controller; equals `postif_inst_ren_o`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL. Reset or flush returns to IDLE, except the WAIT and REQ+addr_ok cases listed below.
- **IDLE**
  - `if_pc_valid_i` & !downstream_stall & aligned PC: latch PC, go to REQ.
  - Misaligned PC (`if_pc_i[1:0] != 0`): latch PC, inst = 0, exception = `EXC_ADEL_IF`, go to DONE. No bus request is issued.
- **REQ**
  - `inst_req_o` = 1 and `inst_addr_o` = latched PC, both held stable until `inst_addr_ok_i`.
  - On addr_ok: go to WAIT.
- **WAIT**
  - On data_ok: capture `inst_rdata_i`, exception = 0, go to DONE.
- **DONE**
  - `postif_inst_valid_o` = 1 and outputs are stable.
  - While downstream_stall: hold.
  - Otherwise the instruction is consumed this cycle. Next state is REQ with the new PC if a new aligned valid PC is present, the DONE misalignment path if the new PC is misaligned, else IDLE.
- **CANCEL**
  - Waits for data_ok, discards the data, goes to IDLE.
  - `postif_inst_ok_o` stays 0.
- **Flush** (`exception_i` = 1) by state:
  - IDLE/DONE/REQ without addr_ok: go to IDLE; the request is withdrawn that cycle.
  - REQ with addr_ok the same cycle: go to CANCEL.
  - WAIT without data_ok: go to CANCEL.
  - WAIT with data_ok the same cycle: data dropped, go to IDLE.
  - In every case outputs clear to reset values.
- Flush has priority over data capture and over new-PC acceptance.
- At most one outstanding transaction. No new request is issued from CANCEL.

## Timing
- Reset values (cycle after `reset_i` = 0 sampled): state IDLE, `inst_req_o` 0, `inst_addr_o` 0, `postif_pc_o` `RESET_PC`, `postif_inst_o` 0, `postif_exception_type_o` 0, all 1-bit outputs 0.
- Reset asserted mid-transaction behaves like a flush, but goes straight to IDLE. The bus is also reset, so there is no CANCEL.
- `inst_req_o`, `inst_addr_o` and all postif outputs are registered or decoded from state only; no combinational path from bus inputs to outputs.
- Zero-wait bus (addr_ok in the first REQ cycle, data_ok the next cycle): PC accepted at cycle N, REQ at N+1, WAIT at N+2, DONE at N+3.
- Back-to-back fetch, DONE→REQ, sustains one instruction per 3 cycles on a zero-wait bus.
- `fetch_stall_o` is high exactly in REQ, WAIT and CANCEL.

## Structure
- Shared package `cpu_defs`:
  - `EXC_ADEL_IF` = 32'h0000_0010 (fetch address error bit).
  - FSM state encoding as 3-bit localparams.
  - Stall-bit indices INST=0, ID=1, EXE=2, DATA=3.
- Single module, no sub-modules. The output holding register and the FSM live together.

## Test plan
- Reset with `reset_i` = 0 for 2 cycles: all outputs at reset values; `inst_req_o` = 0.
- PC 0xBFC0_0000 on a zero-wait bus returning 0x2408_0001: `inst_req_o` high 1 cycle; DONE shows pc 0xBFC0_0000, inst 0x2408_0001, valid = 1, exception = 0.
- PC 0xBFC0_0002: no `inst_req_o`; next cycle valid = 1, inst = 0, exception = 0x10.
- DONE with `stall_i` = 4'b0100 for 3 cycles: outputs unchanged and no new request; on release, the next PC is requested the following cycle.
- Flush in WAIT, data_ok 2 cycles later: state CANCEL, `postif_inst_ok_o` = 0, no valid output; the next request is issued only after IDLE.
- Flush coincident with addr_ok in REQ: go to CANCEL; the late data_ok is dropped and `fetch_stall_o` falls the cycle after it.
